// File: rtl/y86_defs.sv
// Shared Y-86 definitions: instruction codes, status codes, memory-op and
// memory-stage FSM encodings, plus the icode-to-memory-op decode helpers.
package y86_defs;

   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic [1:0] {
      MEM_NONE,
      MEM_READ,
      MEM_WRITE
   } mem_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_FINISH
   } dmem_state_e;

   // Which data-memory access (if any) an instruction performs
   function automatic mem_op_e decode_mem_op(input logic [3:0] icode);
      case (icode)
         IRMMOVQ, IPUSHQ, ICALL: return MEM_WRITE;
         IMRMOVQ, IRET, IPOPQ:   return MEM_READ;
         default:                return MEM_NONE;
      endcase
   endfunction

   // ret/popq address the stack through valA; everything else uses valE
   function automatic logic addr_from_vala(input logic [3:0] icode);
      return (icode == IRET) || (icode == IPOPQ);
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-array data RAM with one 64-bit little-endian write port and one
// 64-bit little-endian combinational read port sharing the same address.
module dmem_ram #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [7:0] mem [MEM_BYTES];

   // Commit all eight bytes of a word write, least-significant byte at addr
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < 8; i++) begin
            mem[addr + AW'(i)] <= wdata[8*i +: 8];
         end
      end
   end

   // Assemble the word at addr, least-significant byte first
   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         rdata[8*i +: 8] = mem[addr + AW'(i)];
      end
   end

endmodule

// File: rtl/data_memory_stage.sv
// Y-86 memory stage: performs the single data-memory access of an
// instruction behind a start/done handshake and reports valM / dmem_error.
module data_memory_stage
   import y86_defs::*;
#(
   parameter int unsigned MEM_BYTES     = 1024,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic [63:0] valE,
   input  logic [63:0] valA,
   input  logic [63:0] valP,
   output logic        busy,
   output logic        done,
   output logic [63:0] valM,
   output logic        dmem_error
);

   localparam int unsigned AW = $clog2(MEM_BYTES);
   localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [63:0]   ADDR_MAX = 64'(MEM_BYTES - 8);
   localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

   dmem_state_e   state_q, state_d;
   mem_op_e       op_q;
   mem_op_e       start_op;
   logic [63:0]   addr_q;
   logic [63:0]   wdata_q;
   logic [CW-1:0] cnt_q;
   logic          in_range;
   logic          access_last;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [63:0]   ram_rdata;

   assign start_op    = decode_mem_op(icode);
   assign in_range    = (addr_q <= ADDR_MAX);
   assign access_last = (state_q == S_ACCESS) && (cnt_q == '0);
   // Write lands on the edge entering FINISH, so a reset during ACCESS
   // can never let a partial or late write through.
   assign ram_we      = access_last && (op_q == MEM_WRITE) && in_range;
   assign ram_addr    = in_range ? addr_q[AW-1:0] : '0;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FINISH);

   dmem_ram #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: accept start only when idle; no-access ops skip ACCESS
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = (start_op == MEM_NONE) ? S_FINISH : S_ACCESS;
         S_ACCESS: if (cnt_q == '0) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Request latch, access countdown and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= MEM_NONE;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         valM       <= '0;
         dmem_error <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q    <= start_op;
                  addr_q  <= addr_from_vala(icode) ? valA : valE;
                  wdata_q <= (icode == ICALL) ? valP : valA;
                  cnt_q   <= CNT_LOAD;
                  if (start_op == MEM_NONE) begin
                     valM       <= '0;
                     dmem_error <= 1'b0;
                  end
               end
            end
            S_ACCESS: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  valM       <= (op_q == MEM_READ && in_range) ? ram_rdata : '0;
                  dmem_error <= !in_range;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_stage.sv
// Self-checking bench for data_memory_stage: a transaction-level model
// (byte array + cycles-remaining counter) checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_data_memory_stage;

   localparam int MEM_BYTES     = 1024;
   localparam int ACCESS_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  icode = 4'h0;
   logic [63:0] valE = '0;
   logic [63:0] valA = '0;
   logic [63:0] valP = '0;
   logic        busy;
   logic        done;
   logic [63:0] valM;
   logic        dmem_error;

   int checks = 0;
   int errors = 0;

   data_memory_stage #(
      .MEM_BYTES     (MEM_BYTES),
      .ACCESS_CYCLES (ACCESS_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .icode      (icode),
      .valE       (valE),
      .valA       (valA),
      .valP       (valP),
      .busy       (busy),
      .done       (done),
      .valM       (valM),
      .dmem_error (dmem_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  mm [MEM_BYTES];
   int          m_rem = 0;        // cycles until the stage is idle again
   logic [3:0]  m_icode = 4'h0;
   logic [63:0] m_valE = '0, m_valA = '0, m_valP = '0;
   logic [63:0] e_valM = '0;
   logic        e_err = 1'b0;

   function automatic bit is_store(input logic [3:0] ic);
      return ic == 4'h4 || ic == 4'hA || ic == 4'h8;
   endfunction
   function automatic bit is_load(input logic [3:0] ic);
      return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
   endfunction

   task automatic model_commit();
      logic [63:0] a, d;
      a = (m_icode == 4'h9 || m_icode == 4'hB) ? m_valA : m_valE;
      d = (m_icode == 4'h8) ? m_valP : m_valA;
      if (!is_store(m_icode) && !is_load(m_icode)) begin
         e_valM = '0; e_err = 1'b0;
      end else if (a > 64'(MEM_BYTES - 8)) begin
         e_valM = '0; e_err = 1'b1;
      end else if (is_store(m_icode)) begin
         for (int k = 0; k < 8; k++) mm[int'(a) + k] = d[8*k +: 8];
         e_valM = '0; e_err = 1'b0;
      end else begin
         for (int k = 0; k < 8; k++) e_valM[8*k +: 8] = mm[int'(a) + k];
         e_err = 1'b0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      int prev;
      if (!rst_n) begin
         m_rem = 0; e_valM = '0; e_err = 1'b0;
      end else begin
         prev = m_rem;
         if (m_rem > 0) begin
            m_rem--;
         end else if (start) begin
            m_icode = icode; m_valE = valE; m_valA = valA; m_valP = valP;
            m_rem = (is_store(icode) || is_load(icode)) ? ACCESS_CYCLES + 1 : 1;
         end
         if (m_rem == 1 && prev != 1) model_commit();
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      chk("busy", busy, (m_rem > 0));
      chk("done", done, (m_rem == 1));
      chk("valM", valM, e_valM);
      chk("dmem_error", dmem_error, e_err);
   end

   // ---------------- directed stimulus ----------------
   task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, output logic [63:0] vm, output logic er,
                         output int lat);
      @(posedge clk); #1;
      icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; icode = 4'h4; valE = ~e; valA = ~a; valP = ~p;
      lat = 0; vm = '0; er = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n; vm = valM; er = dmem_error;
            break;
         end
      end
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL timeout waiting for done icode %h got none expected pulse", ic);
      end
   endtask

   initial begin
      logic [63:0] vm;
      logic        er;
      logic [7:0]  b0;
      int          lat, dcnt, dcyc, bcnt;

      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_valM", valM, 64'h0);
      chk("rst_err", dmem_error, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      // store then load
      run_op(4'h4, 64'h10, 64'h1122334455667788, 64'h0, vm, er, lat);
      chk("st_lat", 64'(lat), 64'd3);
      chk("st_valM", vm, 64'h0);
      run_op(4'h5, 64'h10, 64'h0, 64'h0, vm, er, lat);
      chk("ld_valM", vm, 64'h1122334455667788);
      chk("ld_err", er, 1'b0);
      b0 = vm[7:0];
      chk("ld_byte0", b0, 8'h88);

      // latency + ignored start while busy
      dcnt = 0; dcyc = -1; bcnt = 0;
      @(posedge clk); #1 icode = 4'h5; valE = 64'h10; start = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         start = (n == 2);
         if (n == 2) begin icode = 4'h4; valE = 64'h10; valA = 64'hBAD; end
         @(negedge clk);
         if (done) begin dcnt++; dcyc = n; end
         if (busy) bcnt++;
      end
      chk("hs_done_count", 64'(dcnt), 64'd1);
      chk("hs_done_cycle", 64'(dcyc), 64'd3);
      chk("hs_busy_cycles", 64'(bcnt), 64'd3);

      // range boundary
      run_op(4'h4, 64'd1016, 64'hA5A55A5A0F0FF0F0, 64'h0, vm, er, lat);
      run_op(4'h5, 64'd1016, 64'h0, 64'h0, vm, er, lat);
      chk("rng_1016_valM", vm, 64'hA5A55A5A0F0FF0F0);
      chk("rng_1016_err", er, 1'b0);
      run_op(4'h5, 64'd1017, 64'h0, 64'h0, vm, er, lat);
      chk("rng_1017_err", er, 1'b1);
      chk("rng_1017_valM", vm, 64'h0);
      run_op(4'hA, 64'hFFFFFFFFFFFFFFF8, 64'hDEADBEEFCAFEF00D, 64'h0, vm, er, lat);
      chk("rng_neg_err", er, 1'b1);
      run_op(4'h5, 64'd1016, 64'h0, 64'h0, vm, er, lat);
      chk("rng_unchanged", vm, 64'hA5A55A5A0F0FF0F0);
      chk("rng_err_clear", er, 1'b0);

      // call / ret / popq
      run_op(4'h8, 64'h1F8, 64'h99, 64'h40, vm, er, lat);
      chk("call_err", er, 1'b0);
      run_op(4'h9, 64'h500, 64'h1F8, 64'h0, vm, er, lat);
      chk("ret_valM", vm, 64'h40);
      run_op(4'hB, 64'h8, 64'h1F8, 64'h0, vm, er, lat);
      chk("pop_valM", vm, 64'h40);

      // no-access op
      run_op(4'h6, 64'h10, 64'h77, 64'h0, vm, er, lat);
      chk("nop_lat", 64'(lat), 64'd1);
      chk("nop_valM", vm, 64'h0);
      chk("nop_err", er, 1'b0);
      run_op(4'h5, 64'h10, 64'h0, 64'h0, vm, er, lat);
      chk("nop_ram_kept", vm, 64'h1122334455667788);

      // reset mid-ACCESS aborts the store
      @(posedge clk); #1 icode = 4'h4; valE = 64'h10; valA = '1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_valM", valM, 64'h0);
      chk("abort_err", dmem_error, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_op(4'h5, 64'h10, 64'h0, 64'h0, vm, er, lat);
      chk("abort_old_data", vm, 64'h1122334455667788);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
